// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: one-shot/periodic modes, prescaled
// counting, pause and abort. Owns the count register, prescaler and mode FSM.
module interval_timer_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] period,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic             err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] period_q, period_nx;
  logic             periodic_q, periodic_nx;
  logic             tick_nx, err_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      count      <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      tick       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      count      <= count_nx;
      period_q   <= period_nx;
      periodic_q <= periodic_nx;
      tick       <= tick_nx;
      err        <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    count_nx    = count;
    period_nx   = period_q;
    periodic_nx = periodic_q;
    tick_nx     = 1'b0;
    err_nx      = 1'b0;

    if (stop) begin
      state_nx = IDLE;
      count_nx = '0;
      presc_nx = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (period != '0) begin
              period_nx   = period;
              periodic_nx = periodic;
              count_nx    = '0;
              presc_nx    = '0;
              state_nx    = RUN;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        RUN, PAUSE: begin
          // Leaving PAUSE with pause low counts in that same cycle, so the
          // delay added equals exactly the number of cycles pause was high.
          if (pause) begin
            state_nx = PAUSE;
          end else begin
            state_nx = RUN;
            if (presc != PS_LAST) begin
              presc_nx = presc + PW'(1);
            end else begin
              presc_nx = '0;
              if (count != period_q - WIDTH'(1)) begin
                count_nx = count + WIDTH'(1);
              end else begin
                count_nx = '0;
                tick_nx  = 1'b1;
                state_nx = periodic_q ? RUN : DONE;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule
